// File: rtl/serial_logic_unit.sv
// Bit-serial NAND-only logic unit: NAND/AND/OR/XOR of two WIDTH-bit operands, LSB first.
// Optional feature macro: SLU_PARITY_EN adds a registered parity output (^result).
module serial_logic_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
`ifdef SLU_PARITY_EN
    output logic             parity,
`endif
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [WIDTH-2:0] part;
    logic [WIDTH-1:0] part_wide;
    logic [1:0]       op_q;
    logic [CW-1:0]    cnt;
    logic             accept, last, bit_r;

    function automatic logic nand2(input logic x, input logic y);
        return ~(x & y);
    endfunction

    assign accept = start && (state != S_RUN);
    assign last   = (state == S_RUN) && (cnt == CW'(WIDTH - 1));
    assign busy   = (state == S_RUN);
    assign done   = (state == S_DONE);

    // Every operation is composed purely from 2-input NANDs.
    always_comb begin
        bit_r = nand2(a_sr[0], b_sr[0]);
        case (op_q)
            2'b00: bit_r = nand2(a_sr[0], b_sr[0]);
            2'b01: bit_r = nand2(nand2(a_sr[0], b_sr[0]), nand2(a_sr[0], b_sr[0]));
            2'b10: bit_r = nand2(nand2(a_sr[0], a_sr[0]), nand2(b_sr[0], b_sr[0]));
            2'b11: bit_r = nand2(nand2(a_sr[0], nand2(a_sr[0], b_sr[0])),
                                 nand2(b_sr[0], nand2(a_sr[0], b_sr[0])));
            default: bit_r = nand2(a_sr[0], b_sr[0]);
        endcase
    end

    // New bit enters from the MSB; on the final bit this is the complete word.
    assign part_wide = {bit_r, part};

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_RUN;
            S_RUN:  if (last)  state_next = S_DONE;
            S_DONE: state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // NOTE: the datapath registers are plain flops (not a memory), so they are
    // all cleared by reset to give a fully defined post-reset state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            part   <= '0;
            op_q   <= 2'b00;
            cnt    <= '0;
            result <= '0;
            zero   <= 1'b0;
`ifdef SLU_PARITY_EN
            parity <= 1'b0;
`endif
        end else if (accept) begin
            a_sr <= a;
            b_sr <= b;
            op_q <= op;
            cnt  <= '0;
        end else if (state == S_RUN) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            part <= part_wide[WIDTH-1:1];
            cnt  <= cnt + CW'(1);
            if (last) begin
                result <= part_wide;
                zero   <= (part_wide == '0);
`ifdef SLU_PARITY_EN
                parity <= ^part_wide;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_logic_unit.sv
// Self-checking bench for serial_logic_unit (WIDTH=8) against a word-level reference model.
module tb_serial_logic_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       busy, done, zero;
    logic [7:0] result;
`ifdef SLU_PARITY_EN
    logic       parity;
`endif

    serial_logic_unit #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result),
`ifdef SLU_PARITY_EN
        .parity(parity),
`endif
        .zero(zero)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_res;
    logic [7:0] prev_res;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            2'b00:   return ~(x & y);
            2'b01:   return x & y;
            2'b10:   return x | y;
            default: return x ^ y;
        endcase
    endfunction

    // Called at a negedge: presents a request, then checks the first RUN cycle.
    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic [1:0] o, input string tag);
        a = x; b = y; op = o; start = 1'b1;
        exp_res = model(o, x, y);
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy_after_start"}, busy, 1);
        check({tag, " done_low_in_run"}, done, 0);
        check({tag, " result_held"}, result, prev_res);
    endtask

    // Waits (bounded) for done, optionally scrambling inputs while busy.
    task automatic finish(input bit noise, input string tag);
        int  nb = 0;
        bit  seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) begin
                nb++;
                if (result !== prev_res) check({tag, " no_partial_result"}, result, prev_res);
                if (noise) begin
                    start = 1'($urandom); a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " done_seen"}, seen, 1);
        check({tag, " busy_cycles"}, nb, 8);
        check({tag, " result"}, result, exp_res);
        check({tag, " zero"}, zero, (exp_res == 8'h00));
`ifdef SLU_PARITY_EN
        check({tag, " parity"}, parity, ^exp_res);
`endif
        prev_res = exp_res;
    endtask

    // Done must be a single-cycle pulse and the result must stay put in IDLE.
    task automatic end_op(input string tag);
        @(negedge clk);
        check({tag, " done_pulse_end"}, done, 0);
        check({tag, " idle_busy"}, busy, 0);
        check({tag, " result_hold_idle"}, result, exp_res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset result", result, 0);
        check("reset zero", zero, 0);
`ifdef SLU_PARITY_EN
        check("reset parity", parity, 0);
`endif
        prev_res = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(8'hF0, 8'hCC, 2'b00, "nand");
        finish(1'b0, "nand");
        check("nand literal", result, 8'h3F);

        // Back-to-back: new start issued in the DONE cycle.
        issue(8'hF0, 8'hCC, 2'b01, "and_b2b");
        finish(1'b0, "and_b2b");
        issue(8'hF0, 8'hCC, 2'b10, "or_b2b");
        finish(1'b0, "or_b2b");
        issue(8'hF0, 8'hCC, 2'b11, "xor_b2b");
        finish(1'b0, "xor_b2b");
        check("xor literal", result, 8'h3C);
        end_op("xor_b2b");

        issue(8'h00, 8'hFF, 2'b01, "zero_and");
        finish(1'b0, "zero_and");
        end_op("zero_and");

        issue(8'h01, 8'h00, 2'b10, "or_odd");
        finish(1'b0, "or_odd");
        end_op("or_odd");

        issue(8'hF0, 8'hCC, 2'b00, "noise");
        finish(1'b1, "noise");
        end_op("noise");

        // Reset asserted during the 4th RUN cycle.
        issue(8'hAA, 8'h55, 2'b11, "abort");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort result", result, 0);
        check("abort zero", zero, 0);
        prev_res = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort no_done", done, 0);
        issue(8'h5A, 8'h0F, 2'b10, "after_abort");
        finish(1'b0, "after_abort");
        end_op("after_abort");

        for (int n = 0; n < 24; n++) begin
            issue(8'($urandom), 8'($urandom), 2'($urandom), "rand");
            finish(1'($urandom), "rand");
            if ($urandom_range(1) == 0) end_op("rand");
        end
        end_op("rand_tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
